// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the PLL: turns accepted step/reload requests into
// PHASE_STEP_N / LOAD_PHASE pulses once lock is stable, and tracks per-output phase.
//
// state     | meaning
// IDLE      | waiting for a request, req_ready high
// WAIT_LOCK | counting consecutive pll_lock cycles
// STEP_LO   | phase_step_n held low for one step
// STEP_HI   | phase_step_n held high between steps
// LOAD      | load_phase pulse, position cleared
// DONE      | one-cycle completion pulse
module pll_phase_ctrl #(
  parameter int STEP_LOW  = 4,
  parameter int STEP_GAP  = 8,
  parameter int LOCK_WAIT = 16,
  parameter int CNT_W     = 8,
  parameter int PHASE_W   = 10
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pll_lock,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_sel,
  input  logic               req_dir,
  input  logic [CNT_W-1:0]   req_steps,
  input  logic               req_reload,
  output logic [2:0]         phase_sel,
  output logic               phase_dir,
  output logic               phase_step_n,
  output logic               load_phase,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic [2:0]         pos_rd_sel,
  output logic [PHASE_W-1:0] pos_rd_data
);

  localparam int TMR_MAX = (STEP_LOW > STEP_GAP) ? STEP_LOW : STEP_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int LCK_W   = $clog2(LOCK_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STEP_LO   = 3'd2,
    STEP_HI   = 3'd3,
    LOAD      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic               ready_en;
  logic               reload_q;
  logic [TMR_W-1:0]   tmr;
  logic [LCK_W-1:0]   lock_cnt;
  logic [CNT_W-1:0]   rem;
  logic [PHASE_W-1:0] pos [5];

  logic accept, sel_ok, lock_tc, tmr_tc, last_step, steps_zero;

  assign accept     = req_valid && req_ready;
  assign sel_ok     = (req_sel <= 3'd4);
  assign lock_tc    = pll_lock && (lock_cnt == LCK_W'(LOCK_WAIT - 1));
  assign tmr_tc     = (tmr == '0);
  assign last_step  = (rem == CNT_W'(1));
  assign steps_zero = (req_steps == '0);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && sel_ok) begin
          if (!req_reload && steps_zero) state_nxt = DONE;
          else                           state_nxt = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_tc) state_nxt = reload_q ? LOAD : STEP_LO;
      end
      STEP_LO: begin
        if (!pll_lock)   state_nxt = IDLE;
        else if (tmr_tc) state_nxt = STEP_HI;
      end
      STEP_HI: begin
        if (!pll_lock)   state_nxt = IDLE;
        else if (tmr_tc) state_nxt = last_step ? DONE : STEP_LO;
      end
      LOAD: begin
        state_nxt = pll_lock ? DONE : IDLE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    phase_step_n = 1'b1;
    load_phase   = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        req_ready = ready_en;
        busy      = 1'b0;
      end
      STEP_LO: phase_step_n = 1'b0;
      LOAD:    load_phase   = 1'b1;
      DONE:    done         = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latch, timers, lock counter and position records.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ready_en  <= 1'b0;
      err       <= 1'b0;
      phase_sel <= '0;
      phase_dir <= 1'b0;
      reload_q  <= 1'b0;
      rem       <= '0;
      tmr       <= '0;
      lock_cnt  <= '0;
      for (int i = 0; i < 5; i++) pos[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          lock_cnt <= '0;
          if (accept) begin
            if (!sel_ok) begin
              err <= 1'b1;
            end else begin
              phase_sel <= req_sel;
              phase_dir <= req_dir;
              reload_q  <= req_reload;
              rem       <= req_steps;
            end
          end
        end
        WAIT_LOCK: begin
          tmr <= TMR_W'(STEP_LOW - 1);
          if (!pll_lock) lock_cnt <= '0;
          else           lock_cnt <= lock_cnt + LCK_W'(1);
        end
        STEP_LO: begin
          if (!pll_lock) begin
            err <= 1'b1;
          end else if (tmr_tc) begin
            tmr <= TMR_W'(STEP_GAP - 1);
            for (int i = 0; i < 5; i++) begin
              if (phase_sel == 3'(i))
                pos[i] <= phase_dir ? pos[i] + PHASE_W'(1) : pos[i] - PHASE_W'(1);
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        STEP_HI: begin
          if (!pll_lock) begin
            err <= 1'b1;
          end else if (tmr_tc) begin
            tmr <= TMR_W'(STEP_LOW - 1);
            rem <= rem - CNT_W'(1);
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        LOAD: begin
          if (!pll_lock) begin
            err <= 1'b1;
          end else begin
            for (int i = 0; i < 5; i++) begin
              if (phase_sel == 3'(i)) pos[i] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pos_rd_data = '0;
    for (int i = 0; i < 5; i++) begin
      if (pos_rd_sel == 3'(i)) pos_rd_data = pos[i];
    end
  end

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Dynamic phase-shift controller for the on-chip PLL. It drives the PLL's PHASE_SEL / PHASE_DIR / PHASE_STEP_N / LOAD_PHASE inputs from a simple valid/ready request port. It gates every operation on a stable pll_lock and keeps a wrapping per-output phase-position record for software and debug readback. It sits in the system clock domain between the control logic (register file / calibration FSM) and the PLL instance.

## Interface
- STEP_LOW, 4: cycles phase_step_n is held low per step (≥1)
- STEP_GAP, 8: cycles phase_step_n is held high between steps (≥1)
- LOCK_WAIT, 16: consecutive pll_lock=1 cycles required before acting (≥1)
- CNT_W, 8: width of step-count request
- PHASE_W, 10: width of each phase-position register
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  synchronous, active-low reset
- pll_lock  in  1  PLL lock, already synchronous to sys_clk
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_sel  in  3  target output 0..4
- req_dir  in  1  1 = advance (+1 per step), 0 = retard (−1)
- req_steps  in  CNT_W  number of steps
- req_reload  in  1  pulse load_phase, clear position; overrides req_steps
- phase_sel  out  3  to PLL PHASE_SEL
- phase_dir  out  1  to PLL PHASE_DIR
- phase_step_n  out  1  to PLL PHASE_STEP_N, active low
- load_phase  out  1  to PLL LOAD_PHASE
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- pos_rd_sel  in  3  position readback select
- pos_rd_data  out  PHASE_W  combinational read of pos[pos_rd_sel]; 0 for select >4

## Operation
- Reset values (sys_rst_n=0 at a clock edge): state IDLE, phase_step_n=1, load_phase=0, phase_sel=0, phase_dir=0, done=0, err=0, busy=0, all pos[0..4]=0. req_ready is 0 in the reset cycle and 1 from the first cycle after reset release.
- States: IDLE, WAIT_LOCK, STEP_LO, STEP_HI, LOAD, DONE.
- IDLE: on req_valid&req_ready, latch sel/dir/steps/reload and drive phase_sel/phase_dir from the latched values. These outputs stay stable until the next accept.
  - req_sel>4: no state change; err pulses in the following cycle.
  - req_steps=0 and req_reload=0: go to DONE.
  - Otherwise go to WAIT_LOCK.
- WAIT_LOCK: the lock counter counts consecutive cycles with pll_lock=1 and resets to 0 on pll_lock=0. There is no timeout and no error in this state. When the count reaches LOCK_WAIT, go to LOAD if reload, else to STEP_LO.
- STEP_LO: phase_step_n=0 for STEP_LOW cycles.
  - In the last low cycle, pos[sel] += 1 (dir=1) or −= 1 (dir=0), modulo 2^PHASE_W. 2^PHASE_W−1+1 → 0; 0−1 → all ones.
  - Then go to STEP_HI.
- STEP_HI: phase_step_n=1 for STEP_GAP cycles and decrement the remaining count. Go to DONE if the count reaches 0, else back to STEP_LO.
- LOAD: load_phase=1 for exactly one cycle, pos[sel] cleared to 0, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Lock loss (pll_lock=0) in STEP_LO, STEP_HI or LOAD aborts the operation:
  - phase_step_n returns to 1 and load_phase to 0 next cycle;
  - err pulses one cycle, state goes to IDLE, done is not asserted;
  - a step whose low phase had not completed is not counted; completed steps stay in pos.
- Reset mid-operation: all state and positions return to reset values at that edge.

## Timing
- Let A be the first cycle after the accepting edge (first WAIT_LOCK cycle).
- With pll_lock held high, the first phase_step_n low cycle is A+LOCK_WAIT.
- A step request of N steps produces exactly N low pulses of STEP_LOW cycles each, separated by STEP_GAP high cycles. done is high at cycle A+LOCK_WAIT+N·(STEP_LOW+STEP_GAP), and req_ready is high the cycle after.
- Reload: load_phase is high at A+LOCK_WAIT and done at A+LOCK_WAIT+1.
- A pos update is visible on pos_rd_data the cycle after the last low cycle of that step.
- phase_sel/phase_dir are set-up at least LOCK_WAIT cycles before the first falling edge of phase_step_n.

## Test plan
- Reset then idle: outputs at reset values, req_ready=1 one cycle after release, pos_rd_data=0 for all selects.
- Defaults, lock high, request sel=2 dir=1 steps=3 accepted at edge T: phase_step_n low in cycles T+17..20, T+29..32, T+41..44; done at T+53; pos[2]=3.
- pos[1]=0, sel=1 dir=0 steps=2: pos[1]=1022 (PHASE_W=10). Then dir=1 steps=3: pos[1]=1.
- Lock toggles low at cycle A+10 and stays high after: no err; first low pulse begins 16 cycles after lock returns.
- Lock dropped during the 2nd low pulse of a 5-step request: err pulse, no done, pos[sel] advanced by 1, phase_step_n=1 next cycle, req_ready returns.
- req_sel=6: err pulse, busy never asserted. Reload on sel=0 with pos[0]=5: load_phase one cycle at A+16, done at A+17, pos[0]=0.
